// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/halt/single-step controller for the single-cycle mips core.
// Produces the per-cycle advance enable, takes RUN/HALT/STEP/SET_BP commands over a
// valid/ready port, halts on breakpoint, step exhaustion or command, and counts
// retired instructions.
// Optional feature macro: MIPS_RUN_CTRL_BREAK_INS_EN -- when defined, an executed MIPS
// BREAK instruction halts the controller with cause BRK.
module mips_run_ctrl #(
   parameter int STEP_W = 16
) (
   input  logic        clk,
   input  logic        PcReSet,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic [31:0] pc,
   input  logic [31:0] ins,
   output logic        cpu_en,
   output logic        halted,
   output logic [2:0]  halt_cause,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [1:0] OP_RUN    = 2'b00;
   localparam logic [1:0] OP_HALT   = 2'b01;
   localparam logic [1:0] OP_STEP   = 2'b10;
   localparam logic [1:0] OP_SET_BP = 2'b11;

   localparam logic [2:0] CAUSE_RESET = 3'd0;
   localparam logic [2:0] CAUSE_CMD   = 3'd1;
   localparam logic [2:0] CAUSE_BP    = 3'd2;
   localparam logic [2:0] CAUSE_STEP  = 3'd3;
   localparam logic [2:0] CAUSE_BRK   = 3'd4;

   state_t              state, state_nxt;
   logic [2:0]          cause_nxt;
   logic [STEP_W-1:0]   step_cnt, cnt_nxt;
   logic                skip, skip_nxt;
   logic                bp_valid, bp_valid_nxt;
   logic [31:0]         bp_addr;
   logic                accept;
   logic                bp_hit;
   logic                brk_hit;
   logic [STEP_W-1:0]   step_arg;
   logic                step_zero;

   assign cmd_ready = (state != ST_STEP);
   assign accept    = cmd_valid & cmd_ready;
   assign halted    = (state == ST_HALT);
   // skip masks the breakpoint for the first executed instruction after a resume,
   // so the core can leave the address it stopped on.
   assign bp_hit    = bp_valid & (pc == bp_addr) & ~skip;
   assign cpu_en    = (state != ST_HALT) & ~bp_hit;
   assign step_arg  = cmd_arg[STEP_W-1:0];
   assign step_zero = (step_arg == '0);

`ifdef MIPS_RUN_CTRL_BREAK_INS_EN
   // BREAK is executed (and retired) in the cycle it is seen, then the core stops.
   assign brk_hit = cpu_en & (ins[31:26] == 6'd0) & (ins[5:0] == 6'b001101);
`else
   logic unused_ins;
   assign unused_ins = ^ins;
   assign brk_hit    = 1'b0;
`endif

   // Next-state, halt cause, step count, skip and breakpoint updates.
   always_comb begin
      state_nxt    = state;
      cause_nxt    = halt_cause;
      cnt_nxt      = step_cnt;
      skip_nxt     = skip & ~cpu_en;
      bp_valid_nxt = bp_valid;
      case (state)
         ST_HALT: begin
            if (accept) begin
               case (cmd_op)
                  OP_RUN: begin
                     state_nxt = ST_RUN;
                     skip_nxt  = 1'b1;
                  end
                  OP_STEP: begin
                     if (step_zero) begin
                        cause_nxt = CAUSE_STEP;
                     end else begin
                        state_nxt = ST_STEP;
                        cnt_nxt   = step_arg;
                        skip_nxt  = 1'b1;
                     end
                  end
                  OP_HALT: cause_nxt = CAUSE_CMD;
                  default: ;
               endcase
            end
         end
         ST_RUN, ST_STEP: begin
            if (bp_hit) begin
               state_nxt = ST_HALT;
               cause_nxt = CAUSE_BP;
            end else if (brk_hit) begin
               state_nxt = ST_HALT;
               cause_nxt = CAUSE_BRK;
            end else if (state == ST_STEP) begin
               cnt_nxt = step_cnt - STEP_W'(1);
               if (step_cnt == STEP_W'(1)) begin
                  state_nxt = ST_HALT;
                  cause_nxt = CAUSE_STEP;
               end
            end else if (accept) begin
               case (cmd_op)
                  OP_HALT: begin
                     state_nxt = ST_HALT;
                     cause_nxt = CAUSE_CMD;
                  end
                  OP_STEP: begin
                     if (step_zero) begin
                        state_nxt = ST_HALT;
                        cause_nxt = CAUSE_STEP;
                     end else begin
                        state_nxt = ST_STEP;
                        cnt_nxt   = step_arg;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_nxt = ST_HALT;
      endcase
      // A misaligned breakpoint address disarms the breakpoint.
      if (accept && (cmd_op == OP_SET_BP)) begin
         bp_valid_nxt = (cmd_arg[1:0] == 2'b00);
      end
   end

   // Control registers and retired-instruction counter, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!PcReSet) begin
         state      <= ST_HALT;
         halt_cause <= CAUSE_RESET;
         step_cnt   <= '0;
         skip       <= 1'b0;
         bp_valid   <= 1'b0;
         retired    <= 32'd0;
      end else begin
         state      <= state_nxt;
         halt_cause <= cause_nxt;
         step_cnt   <= cnt_nxt;
         skip       <= skip_nxt;
         bp_valid   <= bp_valid_nxt;
         retired    <= retired + {31'd0, cpu_en};
      end
   end

   // Breakpoint address is only meaningful while bp_valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept && (cmd_op == OP_SET_BP)) begin
         bp_addr <= cmd_arg;
      end
   end

endmodule
